// File: rtl/ubksa_pipe_addsub.sv
// ubksa_pipe_addsub: pipelined unsigned Kogge-Stone adder/subtractor with
// unequal operand widths and a global-stall valid/ready handshake.
//
// Ports
//   CLK, RST             clock (rising edge), synchronous active-high reset
//   IN_VALID / IN_READY  input handshake; IN_READY = !OUT_VALID | OUT_READY
//   X [XW], Y [YW]       operands, both zero-extended to N = max(XW,YW)
//   CI                   carry-in (add mode only)
//   SUB                  0: S = Y + X + CI, 1: S = Y - X
//   TAG_IN [TAGW]        sideband tag travelling with the operation
//   OUT_VALID/OUT_READY  output handshake
//   S [N+1]              result; S[N] = carry out (add) / no-borrow (sub)
//   TAG_OUT [TAGW]       tag belonging to the result on S
module ubksa_pipe_addsub #(
    parameter int XW        = 8,
    parameter int YW        = 10,
    parameter int REG_EVERY = 1,
    parameter int TAGW      = 4,
    localparam int N        = (XW > YW) ? XW : YW
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [XW-1:0]   X,
    input  logic [YW-1:0]   Y,
    input  logic            CI,
    input  logic            SUB,
    input  logic [TAGW-1:0] TAG_IN,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [N:0]      S,
    output logic [TAGW-1:0] TAG_OUT
);

    localparam int unsigned L  = $clog2(N);
    localparam int unsigned LA = (L > 0) ? L : 1;
    localparam int unsigned RD = (REG_EVERY > 0) ? REG_EVERY : 1;
    localparam int unsigned NS = (REG_EVERY > 0) ? (L + RD - 1) / RD : 0;

    // Index one past the last prefix level feeding register stage j.
    function automatic int unsigned grp_end(input int unsigned j);
        return (j * RD > L) ? L : j * RD;
    endfunction

    logic adv;
    assign adv      = !OUT_VALID || OUT_READY;
    assign IN_READY = adv;

    // Stage-0 operand formation
    logic [N-1:0] xe, ye, b;
    logic         cin0;
    always_comb begin
        xe         = '0;
        xe[XW-1:0] = X;
        ye         = '0;
        ye[YW-1:0] = Y;
        b          = SUB ? ~xe : xe;
        cin0       = SUB | CI;
    end

    // Register stages: index 0 is the input register, 1..NS follow prefix groups.
    logic [N-1:0]    rg   [NS+1];
    logic [N-1:0]    rp   [NS+1];
    logic [N-1:0]    rp0  [NS+1];
    logic            rcin [NS+1];
    logic [TAGW-1:0] rtag [NS+1];
    logic            rv   [NS+1];

    // Combinational prefix levels
    logic [N-1:0] lg [LA];
    logic [N-1:0] lp [LA];

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int unsigned SPAN = 1 << k;
        // Low SPAN bits have no partner at distance SPAN: P passes through.
        localparam logic [N-1:0] LOWM = {N{1'b1}} >> (N - SPAN);
        logic [N-1:0] gi, pi;
        if (REG_EVERY > 0 && (k % RD) == 0) begin : g_from_reg
            assign gi = rg[k / RD];
            assign pi = rp[k / RD];
        end else if (k == 0) begin : g_from_in
            assign gi = rg[0];
            assign pi = rp[0];
        end else begin : g_from_lvl
            assign gi = lg[k-1];
            assign pi = lp[k-1];
        end
        assign lg[k] = gi | (pi & (gi << SPAN));
        assign lp[k] = pi & ((pi << SPAN) | LOWM);
    end

    // Final group (G,P) spanning bit 0..i for each i
    logic [N-1:0] gf, pf;
    if (NS > 0) begin : g_fin_reg
        assign gf = rg[NS];
        assign pf = rp[NS];
    end else if (L > 0) begin : g_fin_lvl
        assign gf = lg[L-1];
        assign pf = lp[L-1];
    end else begin : g_fin_none
        assign gf = rg[0];
        assign pf = rp[0];
    end

    logic [N:0] carry, sum;
    assign carry = {gf | (pf & {N{rcin[NS]}}), rcin[NS]};
    assign sum   = {carry[N], rp0[NS] ^ carry[N-1:0]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned j = 0; j <= NS; j++) rv[j] <= 1'b0;
            OUT_VALID <= 1'b0;
            S         <= '0;
            TAG_OUT   <= '0;
        end else if (adv) begin
            rg[0]   <= ye & b;
            rp[0]   <= ye ^ b;
            rp0[0]  <= ye ^ b;
            rcin[0] <= cin0;
            rtag[0] <= TAG_IN;
            rv[0]   <= IN_VALID;
            for (int unsigned j = 1; j <= NS; j++) begin
                rg[j]   <= lg[grp_end(j) - 1];
                rp[j]   <= lp[grp_end(j) - 1];
                rp0[j]  <= rp0[j-1];
                rcin[j] <= rcin[j-1];
                rtag[j] <= rtag[j-1];
                rv[j]   <= rv[j-1];
            end
            OUT_VALID <= rv[NS];
            // Bubbles leave S/TAG_OUT untouched.
            if (rv[NS]) begin
                S       <= sum;
                TAG_OUT <= rtag[NS];
            end
        end
    end

endmodule

// File: tb/tb_ubksa_pipe_addsub.sv
// Bench for ubksa_pipe_addsub: three instances (REG_EVERY = 1, 0, 3) share the
// input stimulus; the REG_EVERY=1 instance sees random back-pressure, the other
// two are always ready. Each has its own scoreboard fed by an arithmetic model.
module tb_ubksa_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst, in_valid, ci, sub, out_ready;
    logic [7:0]  x;
    logic [9:0]  y;
    logic [3:0]  tag_in;

    logic        in_ready, out_valid;
    logic [10:0] s;
    logic [3:0]  tag_out;
    logic        in_ready0, out_valid0;
    logic [10:0] s0;
    logic [3:0]  tag_out0;
    logic        in_ready3, out_valid3;
    logic [10:0] s3;
    logic [3:0]  tag_out3;

    always #5 clk = ~clk;

    ubksa_pipe_addsub #(.XW(8), .YW(10), .REG_EVERY(1), .TAGW(4)) u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .X(x), .Y(y), .CI(ci), .SUB(sub), .TAG_IN(tag_in),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .S(s), .TAG_OUT(tag_out)
    );

    ubksa_pipe_addsub #(.XW(8), .YW(10), .REG_EVERY(0), .TAGW(4)) u_dut_r0 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready0),
        .X(x), .Y(y), .CI(ci), .SUB(sub), .TAG_IN(tag_in),
        .OUT_VALID(out_valid0), .OUT_READY(1'b1), .S(s0), .TAG_OUT(tag_out0)
    );

    ubksa_pipe_addsub #(.XW(8), .YW(10), .REG_EVERY(3), .TAGW(4)) u_dut_r3 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready3),
        .X(x), .Y(y), .CI(ci), .SUB(sub), .TAG_IN(tag_in),
        .OUT_VALID(out_valid3), .OUT_READY(1'b1), .S(s3), .TAG_OUT(tag_out3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [14:0] q_m[$], q_0[$], q_3[$];
    logic [10:0] got_log[$];
    logic        hold_pend = 1'b0;
    logic [10:0] hold_s;
    logic [3:0]  hold_tag;
    logic        acc_m;
    logic        smp_ov [3];
    logic [10:0] smp_s  [3];
    logic [3:0]  smp_tag[3];

    task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tg, got, exp);
        end
    endtask

    // Reference: unsigned arithmetic on the operand values.
    function automatic logic [10:0] ref_s(input logic [7:0] xv, input logic [9:0] yv,
                                          input logic civ, input logic subv);
        int unsigned xx = xv;
        int unsigned yy = yv;
        if (subv) return {(yy >= xx) ? 1'b1 : 1'b0, 10'(yy - xx)};
        return 11'(yy + xx + civ);
    endfunction

    task automatic cycle(input logic v, input logic [7:0] xv, input logic [9:0] yv,
                         input logic civ, input logic subv, input logic [3:0] tg,
                         input logic ordy, input logic r);
        logic [14:0] e;
        @(negedge clk);
        in_valid = v; x = xv; y = yv; ci = civ; sub = subv; tag_in = tg;
        out_ready = ordy; rst = r;
        #1;
        smp_ov[0] = out_valid;  smp_s[0] = s;  smp_tag[0] = tag_out;
        smp_ov[1] = out_valid0; smp_s[1] = s0; smp_tag[1] = tag_out0;
        smp_ov[2] = out_valid3; smp_s[2] = s3; smp_tag[2] = tag_out3;
        acc_m = 1'b0;
        if (!r) begin
            chk("in_ready", in_ready, !out_valid || ordy);
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_s", s, hold_s);
                chk("hold_tag", tag_out, hold_tag);
            end
            if (out_valid && ordy) begin
                chk("sb_m_nonempty", q_m.size() > 0, 1);
                if (q_m.size() > 0) begin
                    e = q_m.pop_front();
                    chk("s_m", s, e[10:0]);
                    chk("tag_m", tag_out, e[14:11]);
                    got_log.push_back(s);
                end
            end
            acc_m = v && in_ready;
            if (acc_m) q_m.push_back({tg, ref_s(xv, yv, civ, subv)});
            hold_pend = out_valid && !ordy;
            hold_s    = s;
            hold_tag  = tag_out;

            chk("in_ready_r0", in_ready0, 1);
            if (out_valid0) begin
                chk("sb_r0_nonempty", q_0.size() > 0, 1);
                if (q_0.size() > 0) begin
                    e = q_0.pop_front();
                    chk("s_r0", s0, e[10:0]);
                    chk("tag_r0", tag_out0, e[14:11]);
                end
            end
            if (v) q_0.push_back({tg, ref_s(xv, yv, civ, subv)});

            chk("in_ready_r3", in_ready3, 1);
            if (out_valid3) begin
                chk("sb_r3_nonempty", q_3.size() > 0, 1);
                if (q_3.size() > 0) begin
                    e = q_3.pop_front();
                    chk("s_r3", s3, e[10:0]);
                    chk("tag_r3", tag_out3, e[14:11]);
                end
            end
            if (v) q_3.push_back({tg, ref_s(xv, yv, civ, subv)});
        end
        @(posedge clk);
        if (r) begin
            q_m.delete(); q_0.delete(); q_3.delete();
            hold_pend = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 8'($urandom), 10'($urandom), 1'b0, 1'b0, 4'($urandom), 1'b1, 1'b0);
    endtask

    // One op into an empty pipe; measure first-valid latency of each instance.
    task automatic lat_test(input string nm, input logic [7:0] xv, input logic [9:0] yv,
                            input logic civ, input logic subv, input logic [3:0] tg,
                            input logic [10:0] es);
        int lat[3];
        lat = '{0, 0, 0};
        cycle(1'b1, xv, yv, civ, subv, tg, 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
            for (int d = 0; d < 3; d++) begin
                if (lat[d] == 0 && smp_ov[d]) begin
                    lat[d] = i;
                    chk({nm, "_s"}, smp_s[d], es);
                    chk({nm, "_tag"}, smp_tag[d], tg);
                end
            end
        end
        chk({nm, "_lat_re1"}, lat[0], 6);
        chk({nm, "_lat_re0"}, lat[1], 2);
        chk({nm, "_lat_re3"}, lat[2], 4);
    endtask

    initial begin
        int base, sent, k;
        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; ci = 1'b0; sub = 1'b0;
        tag_in = '0; out_ready = 1'b0;

        cycle(1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        idle(1);
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid", smp_ov[d], 0);
            chk("rst_s", smp_s[d], 0);
            chk("rst_tag", smp_tag[d], 0);
        end

        // T1: add with full carry chain
        lat_test("t1", 8'hFF, 10'h3FF, 1'b1, 1'b0, 4'd3, 11'h4FF);

        // T2: back-to-back subtractions, borrow and no-borrow
        base = got_log.size();
        cycle(1'b1, 8'd7, 10'd5, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0);
        cycle(1'b1, 8'd5, 10'd7, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
        idle(10);
        chk("t2_count", got_log.size() - base, 2);
        if (got_log.size() >= base + 2) begin
            chk("t2_first", got_log[base], 11'h3FE);
            chk("t2_second", got_log[base+1], 11'h402);
        end

        // T3: 8-op stream with a 4-cycle consumer stall
        base = got_log.size();
        sent = 0;
        for (int i = 0; i < 30; i++) begin
            k = sent;
            cycle(sent < 8, 8'(k * 37 + 1), 10'(k * 101 + 7), k[0], k[1], 4'(k),
                  !(i >= 6 && i < 10), 1'b0);
            if (acc_m) sent++;
        end
        chk("t3_sent", sent, 8);
        chk("t3_count", got_log.size() - base, 8);

        // T4: reset with three ops in flight
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 8'(i + 10), 10'(i + 20), 1'b0, 1'b0, 4'(i), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        idle(1);
        chk("t4_valid", smp_ov[0], 0);
        chk("t4_s", smp_s[0], 0);
        for (int i = 0; i < 8; i++) begin
            idle(1);
            chk("t4_none_re1", smp_ov[0], 0);
            chk("t4_none_re3", smp_ov[2], 0);
        end

        // T5: latency of all three register arrangements
        lat_test("t5", 8'h80, 10'h200, 1'b0, 1'b0, 4'd9, 11'h280);

        // T6: random traffic and back-pressure
        for (int i = 0; i < 10000; i++)
            cycle($urandom_range(0, 9) < 7, 8'($urandom), 10'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom), $urandom_range(0, 3) != 0, 1'b0);
        idle(12);
        chk("drain_re1", q_m.size(), 0);
        chk("drain_re0", q_0.size(), 0);
        chk("drain_re3", q_3.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
